// File: rtl/pat_gen_pkg.sv
// rtl/pat_gen_pkg.sv - shared state encodings, constants and defaults for pat_gen
package pat_gen_pkg;

    localparam int PAT_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 4;

    // BBCBB with B=1, C=0
    localparam logic [4:0] PAT_BBCBB = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_SEND = 4'b0010,
        S_GAP  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

endpackage

// File: rtl/pat_gen_shreg.sv
// rtl/pat_gen_shreg.sv - loadable left-shift register presenting its MSB at d_o
module pat_gen_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] load_val_i,
    output logic         d_o
);

    logic [W-1:0] r_sr;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_sr <= '0;
        end else if (load_i) begin
            r_sr <= load_val_i;
        end else if (shift_i) begin
            r_sr <= {r_sr[W-2:0], 1'b0};
        end
    end

    assign d_o = r_sr[W-1];

endmodule

// File: rtl/pat_gen.sv
// rtl/pat_gen.sv - serial pattern generator with repeat count and inter-repeat gap
module pat_gen
    import pat_gen_pkg::*;
#(
    parameter int   PAT_W = PAT_W_DEFAULT,
    parameter int   CNT_W = CNT_W_DEFAULT,
    localparam int  LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [CNT_W-1:0] rep_i,
    input  logic [CNT_W-1:0] gap_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_gap;
    logic [PAT_W-1:0]   r_pat;
    logic [LEN_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_rep_cnt;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic               w_len_ok;
    logic               w_accept;
    logic [PAT_W-1:0]   w_aligned;
    logic [LEN_W-1:0]   w_bit_nxt;
    logic [CNT_W-1:0]   w_rep_nxt;
    logic [CNT_W-1:0]   w_gapc_nxt;
    logic               w_sr_load;
    logic               w_sr_shift;
    logic               w_sr_clear;
    logic [PAT_W-1:0]   w_sr_val;

    // Active field is left-aligned so the shifter's MSB is always the next bit out.
    assign w_len_ok  = (len_i != '0) && (len_i <= PAT_W_L);
    assign w_aligned = pattern_i << (PAT_W_L - len_i);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_bit_nxt   = r_bit_cnt;
        w_rep_nxt   = r_rep_cnt;
        w_gapc_nxt  = r_gap_cnt;
        w_sr_load   = 1'b0;
        w_sr_shift  = 1'b0;
        w_sr_clear  = 1'b0;
        w_sr_val    = r_pat;
        case (r_state)
            S_IDLE: begin
                if (start_i && w_len_ok) begin
                    w_state_nxt = S_SEND;
                    w_accept    = 1'b1;
                    w_bit_nxt   = len_i - LEN_W'(1);
                    w_rep_nxt   = rep_i;
                    w_sr_load   = 1'b1;
                    w_sr_val    = w_aligned;
                end
            end
            S_SEND: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                    w_sr_clear  = 1'b1;
                end else if (r_bit_cnt != '0) begin
                    w_bit_nxt  = r_bit_cnt - LEN_W'(1);
                    w_sr_shift = 1'b1;
                end else if (r_rep_cnt != '0) begin
                    w_rep_nxt = r_rep_cnt - CNT_W'(1);
                    w_bit_nxt = r_len - LEN_W'(1);
                    if (r_gap != '0) begin
                        w_state_nxt = S_GAP;
                        w_gapc_nxt  = r_gap - CNT_W'(1);
                        w_sr_clear  = 1'b1;
                    end else begin
                        w_sr_load = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_DONE;
                    w_sr_clear  = 1'b1;
                end
            end
            S_GAP: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                    w_sr_clear  = 1'b1;
                end else if (r_gap_cnt != '0) begin
                    w_gapc_nxt = r_gap_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = S_SEND;
                    w_sr_load   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sr_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_gap     <= '0;
            r_pat     <= '0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_rep_cnt <= w_rep_nxt;
            r_gap_cnt <= w_gapc_nxt;
            if (w_accept) begin
                r_len <= len_i;
                r_gap <= gap_i;
                r_pat <= w_aligned;
            end
            r_valid <= (w_state_nxt == S_SEND);
            r_busy  <= (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    pat_gen_shreg #(
        .W (PAT_W)
    ) u_shreg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (w_sr_clear),
        .load_i     (w_sr_load),
        .shift_i    (w_sr_shift),
        .load_val_i (w_sr_val),
        .d_o        (d_o)
    );

    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_pat_gen.sv
// tb/tb_pat_gen.sv - directed self-checking bench for pat_gen
module tb_pat_gen;
    import pat_gen_pkg::*;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [PAT_W-1:0] pattern_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic [CNT_W-1:0] rep_i = '0;
    logic [CNT_W-1:0] gap_i = '0;
    logic             d_o;
    logic             valid_o;
    logic             busy_o;
    logic             done_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] cap_bits;
    logic [63:0] cap_vseq;
    int          cap_nbits;
    int          cap_busy;
    int          cap_ncyc;
    int          cap_bad;
    logic        cap_done;

    logic [4:0]  det_hist;
    int          det_cnt;
    logic        det_clr = 1'b1;

    always #5 clk = ~clk;

    pat_gen #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .pattern_i (pattern_i),
        .len_i     (len_i),
        .rep_i     (rep_i),
        .gap_i     (gap_i),
        .d_o       (d_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    // Reference BBCBB detector fed by the valid-qualified serial stream
    always @(posedge clk) begin
        if (det_clr) begin
            det_hist <= '0;
            det_cnt  <= 0;
        end else if (valid_o) begin
            det_hist <= {det_hist[3:0], d_o};
            if ({det_hist[3:0], d_o} == PAT_BBCBB) det_cnt <= det_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [7:0] pat, input logic [3:0] len,
                        input logic [3:0] rep, input logic [3:0] gap);
        pattern_i = pat;
        len_i     = len;
        rep_i     = rep;
        gap_i     = gap;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic collect();
        bit stop;
        stop      = 1'b0;
        cap_bits  = '0;
        cap_vseq  = '0;
        cap_nbits = 0;
        cap_busy  = 0;
        cap_ncyc  = 0;
        cap_bad   = 0;
        cap_done  = 1'b0;
        for (int i = 0; i < 200 && !stop; i++) begin
            if (done_o) begin
                cap_done = 1'b1;
                if (busy_o || valid_o || d_o) cap_bad++;
                stop = 1'b1;
            end else begin
                cap_ncyc++;
                cap_vseq = {cap_vseq[62:0], valid_o};
                if (busy_o) cap_busy++;
                else cap_bad++;
                if (valid_o) begin
                    cap_bits = {cap_bits[62:0], d_o};
                    cap_nbits++;
                end else if (d_o) begin
                    cap_bad++;
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({d_o, valid_o, busy_o, done_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp 0000", {d_o, valid_o, busy_o, done_o});
        end
        rst_i = 1'b0;
        tick();
        n_tests++;
        if ({d_o, valid_o, busy_o, done_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset got %b exp 0000", {d_o, valid_o, busy_o, done_o});
        end
    endtask

    task automatic test_single();
        fire(8'h1B, 4'd5, 4'd0, 4'd0);
        collect();
        n_tests++;
        if (cap_done !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done_timeout got %b exp 1", cap_done);
        end
        n_tests++;
        if (cap_bits !== 64'b11011 || cap_nbits != 5) begin
            n_fail++;
            $display("FAIL single_bits got %b/%0d exp 11011/5", cap_bits[7:0], cap_nbits);
        end
        n_tests++;
        if (cap_busy != 5 || cap_ncyc != 5 || cap_bad != 0) begin
            n_fail++;
            $display("FAIL single_busy got %0d/%0d/%0d exp 5/5/0", cap_busy, cap_ncyc, cap_bad);
        end
        tick();
        n_tests++;
        if ({valid_o, busy_o, done_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_done_pulse got %b exp 000", {valid_o, busy_o, done_o});
        end
    endtask

    task automatic test_gap();
        fire(8'h1B, 4'd5, 4'd1, 4'd2);
        collect();
        tick();
        n_tests++;
        if (cap_done !== 1'b1 || cap_bits !== 64'b1101111011 || cap_nbits != 10) begin
            n_fail++;
            $display("FAIL gap_bits got %b/%b/%0d exp 1/1101111011/10", cap_done, cap_bits[9:0], cap_nbits);
        end
        n_tests++;
        if (cap_vseq !== 64'b111110011111 || cap_busy != 12 || cap_ncyc != 12 || cap_bad != 0) begin
            n_fail++;
            $display("FAIL gap_timing got %b/%0d/%0d/%0d exp 111110011111/12/12/0",
                     cap_vseq[11:0], cap_busy, cap_ncyc, cap_bad);
        end
    endtask

    task automatic test_back_to_back();
        fire(8'hA5, 4'd8, 4'd2, 4'd0);
        collect();
        tick();
        n_tests++;
        if (cap_done !== 1'b1 || cap_bits !== 64'hA5A5A5 || cap_nbits != 24) begin
            n_fail++;
            $display("FAIL b2b_bits got %b/%h/%0d exp 1/a5a5a5/24", cap_done, cap_bits[23:0], cap_nbits);
        end
        n_tests++;
        if (cap_vseq !== 64'hFFFFFF || cap_busy != 24 || cap_bad != 0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_timing got %h/%0d/%0d/%b exp ffffff/24/0/0",
                     cap_vseq[23:0], cap_busy, cap_bad, done_o);
        end
    endtask

    task automatic test_len1();
        fire(8'hFF, 4'd1, 4'd2, 4'd3);
        collect();
        tick();
        n_tests++;
        if (cap_done !== 1'b1 || cap_bits !== 64'b111 || cap_vseq !== 64'b100010001 ||
            cap_busy != 9 || cap_bad != 0) begin
            n_fail++;
            $display("FAIL len1 got %b/%b/%b/%0d/%0d exp 1/111/100010001/9/0",
                     cap_done, cap_bits[2:0], cap_vseq[8:0], cap_busy, cap_bad);
        end
    endtask

    task automatic test_abort();
        fire(8'h1B, 4'd5, 4'd1, 4'd2);
        tick();
        tick();
        n_tests++;
        if ({valid_o, d_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_third_bit got %b exp 10", {valid_o, d_o});
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        n_tests++;
        if ({d_o, valid_o, busy_o, done_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_outputs got %b exp 0000", {d_o, valid_o, busy_o, done_o});
        end
        fire(8'hA5, 4'd8, 4'd0, 4'd0);
        collect();
        tick();
        n_tests++;
        if (cap_done !== 1'b1 || cap_bits !== 64'hA5 || cap_nbits != 8 || cap_bad != 0) begin
            n_fail++;
            $display("FAIL abort_restart got %b/%h/%0d/%0d exp 1/a5/8/0",
                     cap_done, cap_bits[7:0], cap_nbits, cap_bad);
        end
    endtask

    task automatic test_start_ignored();
        fire(8'h1B, 4'd5, 4'd0, 4'd0);
        pattern_i = 8'h00;
        len_i     = 4'd3;
        rep_i     = 4'd2;
        start_i   = 1'b1;
        collect();
        start_i   = 1'b0;
        n_tests++;
        if (cap_done !== 1'b1 || cap_bits !== 64'b11011 || cap_nbits != 5 || cap_busy != 5) begin
            n_fail++;
            $display("FAIL busy_start got %b/%b/%0d/%0d exp 1/11011/5/5",
                     cap_done, cap_bits[4:0], cap_nbits, cap_busy);
        end
        tick();
        n_tests++;
        if ({valid_o, busy_o, done_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL busy_start_idle got %b exp 000", {valid_o, busy_o, done_o});
        end
    endtask

    task automatic test_reset_gap();
        int seen;
        fire(8'h1B, 4'd5, 4'd1, 4'd2);
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if ({valid_o, busy_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_in_gap_state got %b exp 01", {valid_o, busy_o});
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_tests++;
        if ({d_o, valid_o, busy_o, done_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_in_gap_outputs got %b exp 0000", {d_o, valid_o, busy_o, done_o});
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_o || busy_o || valid_o) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_in_gap_quiet got %0d exp 0", seen);
        end
    endtask

    task automatic test_bad_len();
        int seen;
        logic [3:0] lens [3];
        lens[0] = 4'd0;
        lens[1] = 4'd9;
        lens[2] = 4'd15;
        for (int k = 0; k < 3; k++) begin
            seen      = 0;
            pattern_i = 8'hFF;
            len_i     = lens[k];
            rep_i     = 4'd0;
            gap_i     = 4'd0;
            start_i   = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (done_o || busy_o || valid_o) seen++;
            end
            start_i = 1'b0;
            n_tests++;
            if (seen != 0) begin
                n_fail++;
                $display("FAIL bad_len_%0d got %0d active cycles exp 0", lens[k], seen);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        abort_i = 1'b1;
        fire(8'h1B, 4'd5, 4'd0, 4'd0);
        abort_i = 1'b0;
        collect();
        tick();
        n_tests++;
        if (cap_done !== 1'b1 || cap_bits !== 64'b11011 || cap_nbits != 5) begin
            n_fail++;
            $display("FAIL start_abort_idle got %b/%b/%0d exp 1/11011/5",
                     cap_done, cap_bits[4:0], cap_nbits);
        end
    endtask

    task automatic test_loopback();
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        fire(8'h1B, 4'd5, 4'd3, 4'd1);
        collect();
        tick();
        n_tests++;
        if (det_cnt != 4 || cap_done !== 1'b1) begin
            n_fail++;
            $display("FAIL loopback_detects got %0d/%b exp 4/1", det_cnt, cap_done);
        end
        n_tests++;
        if (cap_busy != 23 || cap_nbits != 20 || cap_bad != 0) begin
            n_fail++;
            $display("FAIL loopback_busy got %0d/%0d/%0d exp 23/20/0", cap_busy, cap_nbits, cap_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_len1();
        test_abort();
        test_start_ignored();
        test_reset_gap();
        test_bad_len();
        test_start_abort_idle();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pat_gen.md
PAT_GEN -- requirements
Module: pat_gen

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- PAT_W, 8: maximum pattern length in bits.
- CNT_W, 4: width of the repeat and gap count fields.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk_i, in, 1: sole clock, rising-edge.
- rst_i, in, 1: synchronous, active-high reset.
- start_i, in, 1: command request.
- abort_i, in, 1: cancel the transfer in progress.
- pattern_i, in, PAT_W: bits to send; the active field is [len_i-1:0].
- len_i, in, clog2(PAT_W)+1: pattern length, 1..PAT_W.
- rep_i, in, CNT_W: extra repetitions; total transmissions = rep_i+1.
- gap_i, in, CNT_W: idle cycles inserted between repetitions.
- d_o, out, 1: serial data bit.
- valid_o, out, 1: d_o qualifier, intended to drive a detector's valid_i.
- busy_o, out, 1: transfer in progress.
- done_o, out, 1: one-cycle completion pulse.

Function
REQ-003 The block SHALL use a one-hot FSM with states S_IDLE, S_SEND, S_GAP and S_DONE.
REQ-004 In S_IDLE, when start_i=1 and 1<=len_i<=PAT_W at a clock edge, the block SHALL latch pattern_i, len_i, rep_i and gap_i and enter S_SEND.
REQ-005 In S_IDLE, a start_i with len_i=0 or len_i>PAT_W SHALL be ignored: the block stays in S_IDLE and asserts neither busy_o nor done_o.
REQ-006 All outputs SHALL be registered; the first bit SHALL appear on d_o with valid_o=1 in the cycle immediately after the accepting edge.
REQ-007 Bits SHALL be sent MSB-first from the latched field, latched pattern bit len-1 down to bit 0, one bit per cycle, with valid_o=1 on every bit.
REQ-008 After bit 0, if repetitions remain and gap>0, the block SHALL enter S_GAP for exactly gap cycles with valid_o=0 and d_o=0, then return to S_SEND.
REQ-009 If repetitions remain and gap=0, the next repetition's MSB SHALL follow bit 0 with no idle cycle.
REQ-010 After the final bit of the last repetition, the block SHALL enter S_DONE for one cycle, with done_o=1, busy_o=0 and valid_o=0, then return to S_IDLE.
REQ-011 busy_o SHALL be 1 in exactly the cycles spent in S_SEND and S_GAP.
REQ-012 start_i SHALL be ignored in S_SEND, S_GAP and S_DONE, and SHALL NOT modify the latched command.
REQ-013 abort_i=1 in S_SEND or S_GAP SHALL force S_IDLE at that edge, so that the following cycle has valid_o=0, busy_o=0 and done_o=0.
REQ-014 abort_i SHALL be ignored in S_IDLE and S_DONE.
REQ-015 When start_i and abort_i are both 1 in S_IDLE, start_i SHALL take effect.
REQ-016 The bit counter SHALL count down from len-1 to 0, and the repeat and gap counters SHALL count down to 0; no counter SHALL wrap.
REQ-017 A full command SHALL occupy exactly len*(rep+1) + gap*rep busy cycles.

Reset
REQ-018 When rst_i=1 at an edge, the FSM SHALL enter S_IDLE, and d_o, valid_o, busy_o and done_o SHALL be 0 in the following cycle.
REQ-019 Reset SHALL clear all counters and the latched command, and SHALL take priority over start_i and abort_i.
REQ-020 Reset asserted mid-transfer SHALL abandon the transfer with no done_o pulse.

Structure
REQ-021 The package pat_gen_pkg SHALL hold:
- the one-hot state encodings S_IDLE, S_SEND, S_GAP and S_DONE;
- a constant PAT_BBCBB = 5'b11011 (B=1, C=0);
- the default PAT_W and CNT_W.
REQ-022 A single sub-module, pat_gen_shreg (a loadable left-shift register presenting its MSB at d_o), SHALL hold the pattern; the FSM and counters SHALL reside in pat_gen.

Verification
REQ-023 pattern_i=8'h1B, len=5, rep=0, gap=0, start pulse -> d_o=1,1,0,1,1 with valid_o=1 on five consecutive cycles, then done_o=1 for one cycle, busy_o high for 5 cycles.
REQ-024 Same pattern with rep=1, gap=2 -> 11011, two cycles with valid_o=0, 11011, then done_o; busy_o high for 12 cycles.
REQ-025 len=8, pattern_i=8'hA5, rep=2, gap=0 -> 24 back-to-back valid bits 10100101 repeated three times, then a single done_o.
REQ-026 abort_i=1 during the 3rd bit of the first repetition -> valid_o and busy_o are 0 on the next cycle, no done_o, and a new start is accepted in the following cycle.
REQ-027 rst_i=1 during S_GAP -> all outputs 0 on the next cycle, no done_o; a start_i during busy and a start_i with len_i=0 in idle are both ignored.
REQ-028 Loopback into the team's BBCBB (11011) detector with pattern=11011, rep=3, gap=1 -> exactly 4 detection pulses.
